// File: rtl/tdc_pkg.sv
// Shared definitions for the TDC frame readout controller.
package tdc_pkg;

  localparam int unsigned BITS_UNSIG_TDC = 15;
  localparam int unsigned NUM_COL        = 16;
  localparam int unsigned CNT_COL        = 4;
  localparam int unsigned FRAME_BITS     = NUM_COL * BITS_UNSIG_TDC;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_MEAS = 3'd1,
    ST_LOAD      = 3'd2,
    ST_SHIFT     = 3'd3,
    ST_DONE      = 3'd4
  } state_t;

endpackage

// File: rtl/tdc_deser.sv
// Serial-in word shifter: collects W bits MSB first and flags the completing edge.
module tdc_deser
  import tdc_pkg::*;
#(
  parameter int unsigned W = BITS_UNSIG_TDC
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_clear,
  input  logic         i_en,
  input  logic         i_sdi,
  output logic [W-1:0] o_word,
  output logic         o_word_done
);

  localparam int unsigned CW = $clog2(W);
  localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

  logic [W-1:0]  r_shift;
  logic [CW-1:0] r_bit_cnt;

  // Shift in one bit per enabled edge; clear discards any partial word.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_clear) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (i_en) begin
      r_shift   <= {r_shift[W-2:0], i_sdi};
      r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CW'(1);
    end
  end

  // The completed word includes the bit being sampled on this edge.
  assign o_word      = {r_shift[W-2:0], i_sdi};
  assign o_word_done = i_en && !i_clear && (r_bit_cnt == LAST_BIT);

endmodule

// File: rtl/tdc_readout_ctrl.sv
// Frame readout controller: strobes column load, deserializes the chain tail
// into column-tagged words on a valid/ready port.
module tdc_readout_ctrl
  import tdc_pkg::*;
#(
  parameter int unsigned BITS_UNSIG_TDC = tdc_pkg::BITS_UNSIG_TDC,
  parameter int unsigned NUM_COL        = tdc_pkg::NUM_COL,
  parameter int unsigned CNT_COL        = tdc_pkg::CNT_COL,
  parameter logic [15:0] TIMEOUT_CYC    = 16'hFFFF
) (
  input  logic                      clk,
  input  logic                      rst_tdc_readout_ctrl,
  input  logic                      start,
  input  logic                      abort,
  input  logic                      meas_done,
  input  logic                      chain_so,
  output logic                      flag_col,
  output logic                      busy,
  output logic [BITS_UNSIG_TDC-1:0] out_data,
  output logic [CNT_COL-1:0]        out_col,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      frame_done,
  output logic                      err_timeout,
  output logic                      err_overflow
);

  state_t r_state;
  state_t w_next;

  logic                      r_flag_col;
  logic                      r_out_valid;
  logic [BITS_UNSIG_TDC-1:0] r_out_data;
  logic [CNT_COL-1:0]        r_out_col;
  logic                      r_err_timeout;
  logic                      r_err_overflow;
  logic [CNT_COL-1:0]        r_col_cnt;
  logic [15:0]               r_to_cnt;

  logic [BITS_UNSIG_TDC-1:0] w_word;
  logic                      w_word_done;
  logic                      w_shift_en;
  logic                      w_deser_clear;
  logic                      w_start_frame;
  logic                      w_timeout_hit;
  logic                      w_last_word;
  logic                      w_accept;

  assign w_shift_en    = (r_state == ST_SHIFT);
  assign w_deser_clear = abort || (r_state != ST_SHIFT);

  tdc_deser #(
    .W (BITS_UNSIG_TDC)
  ) u_deser (
    .i_clk       (clk),
    .i_rst       (rst_tdc_readout_ctrl),
    .i_clear     (w_deser_clear),
    .i_en        (w_shift_en),
    .i_sdi       (chain_so),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  // Next-state decode; abort overrides every transition.
  always_comb begin
    w_next        = r_state;
    w_start_frame = (r_state == ST_IDLE) && start && !abort;
    w_timeout_hit = (r_state == ST_WAIT_MEAS) && (r_to_cnt == TIMEOUT_CYC - 16'd1);
    w_last_word   = w_word_done && (r_col_cnt == CNT_COL'(NUM_COL - 1));
    w_accept      = w_word_done && (!r_out_valid || out_ready);
    case (r_state)
      ST_IDLE:      if (w_start_frame) w_next = ST_WAIT_MEAS;
      ST_WAIT_MEAS: begin
        if (meas_done)          w_next = ST_LOAD;
        else if (w_timeout_hit) w_next = ST_IDLE;
      end
      ST_LOAD:      w_next = ST_SHIFT;
      ST_SHIFT:     if (w_last_word) w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  // State register; flag_col is registered so it is high exactly while in LOAD.
  always_ff @(posedge clk or posedge rst_tdc_readout_ctrl) begin
    if (rst_tdc_readout_ctrl) begin
      r_state    <= ST_IDLE;
      r_flag_col <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_flag_col <= (w_next == ST_LOAD);
    end
  end

  // Timeout and column counters, cleared at frame start and on abort.
  always_ff @(posedge clk or posedge rst_tdc_readout_ctrl) begin
    if (rst_tdc_readout_ctrl) begin
      r_to_cnt  <= '0;
      r_col_cnt <= '0;
    end else if (w_start_frame || abort) begin
      r_to_cnt  <= '0;
      r_col_cnt <= '0;
    end else begin
      r_to_cnt  <= (r_state == ST_WAIT_MEAS) ? r_to_cnt + 16'd1 : '0;
      if (w_word_done) r_col_cnt <= r_col_cnt + CNT_COL'(1);
    end
  end

  // Sticky error flags, cleared only when a new frame is armed.
  always_ff @(posedge clk or posedge rst_tdc_readout_ctrl) begin
    if (rst_tdc_readout_ctrl) begin
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else if (w_start_frame) begin
      r_err_timeout  <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      if (w_timeout_hit && !meas_done && !abort) r_err_timeout <= 1'b1;
      if (w_word_done && !w_accept)              r_err_overflow <= 1'b1;
    end
  end

  // Output holding register: a new word replaces the held one only if it was
  // empty or being consumed on the same edge; otherwise the new word is lost.
  always_ff @(posedge clk or posedge rst_tdc_readout_ctrl) begin
    if (rst_tdc_readout_ctrl) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_col   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_word;
      r_out_col   <= CNT_COL'(NUM_COL - 1) - r_col_cnt;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign flag_col     = r_flag_col;
  assign busy         = (r_state != ST_IDLE);
  assign frame_done   = (r_state == ST_DONE);
  assign out_valid    = r_out_valid;
  assign out_data     = r_out_data;
  assign out_col      = r_out_col;
  assign err_timeout  = r_err_timeout;
  assign err_overflow = r_err_overflow;

endmodule

// File: tb/tb_tdc_readout_ctrl.sv
// Scoreboard bench for tdc_readout_ctrl with a behavioural column-chain model.
module tb_tdc_readout_ctrl;
  import tdc_pkg::*;

  localparam int unsigned W  = BITS_UNSIG_TDC;
  localparam int unsigned NC = NUM_COL;
  localparam int unsigned FB = FRAME_BITS;

  logic clk = 1'b0;
  logic rst, start, abort, meas_done, chain_so, out_ready;
  logic flag_col, busy, out_valid, frame_done, err_timeout, err_overflow;
  logic [W-1:0] out_data;
  logic [3:0]   out_col;

  always #5 clk = ~clk;

  tdc_readout_ctrl #(
    .TIMEOUT_CYC (16'd20)
  ) dut (
    .clk                  (clk),
    .rst_tdc_readout_ctrl (rst),
    .start                (start),
    .abort                (abort),
    .meas_done            (meas_done),
    .chain_so             (chain_so),
    .flag_col             (flag_col),
    .busy                 (busy),
    .out_data             (out_data),
    .out_col              (out_col),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .frame_done           (frame_done),
    .err_timeout          (err_timeout),
    .err_overflow         (err_overflow)
  );

  typedef struct packed {
    logic [3:0]   col;
    logic [W-1:0] data;
  } word_t;

  word_t        exp_q[$];
  logic [W-1:0] col_word [NC];
  logic [FB-1:0] chain = '0;
  int checks = 0;
  int failures = 0;
  int flag_seen = 0;
  int flag_exp = 0;
  logic prev_flag = 1'b0;
  bit m_full = 1'b0;

  // Chain tail view: column NC-1 leaves first, each word MSB first.
  function automatic logic [FB-1:0] pack_frame();
    logic [FB-1:0] f;
    f = '0;
    for (int i = 0; i < int'(NC); i++) f[FB-1-W*i -: W] = col_word[NC-1-i];
    return f;
  endfunction

  // Columns capture on the flag_col cycle, then the chain shifts one bit per clock.
  always @(posedge clk) begin
    if (flag_col) chain <= pack_frame();
    else          chain <= chain << 1;
  end
  assign chain_so = chain[FB-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: consumes one expected word per handshake; watches flag_col pulses.
  always @(negedge clk) begin
    word_t e;
    if (flag_col) begin
      flag_seen++;
      chk("flag_col_double", prev_flag, 0);
    end
    prev_flag = flag_col;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual col=%0d data=%0h required=none", out_col, out_data);
      end else begin
        e = exp_q.pop_front();
        chk("word_col", 32'(out_col), 32'(e.col));
        chk("word_data", 32'(out_data), 32'(e.data));
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_flag_col"}, flag_col, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_out_col"}, 32'(out_col), 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_err_timeout"}, err_timeout, 0);
    chk({tag, "_err_overflow"}, err_overflow, 0);
  endtask

  // mode: 0 ready always high, 1 ready always low, 2 random ready.
  // abort_j/start_j/rst_j: cycle offset from the load cycle L (0 = unused).
  task automatic run_frame(input int meas_d, input int mode, input int abort_j,
                           input int start_j, input int rst_j, input bit nominal);
    bit r;
    bit m_ovf;
    int k;
    word_t w;
    m_ovf = 1'b0;
    for (int c = 0; c < int'(NC); c++)
      col_word[c] = nominal ? W'(15'h4000 + c) : W'($urandom);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_busy", busy, 1);
    chk("start_err_timeout", err_timeout, 0);
    chk("start_err_overflow", err_overflow, 0);
    repeat (meas_d - 1) tick();
    meas_done = 1'b1;
    tick();
    meas_done = 1'b0;
    flag_exp++;
    chk("load_flag_col", flag_col, 1);
    for (int j = 1; j <= 243; j++) begin
      tick();
      if (j == rst_j) begin
        #2 rst = 1'b1;
        #1 chk_all_zero("midreset");
        #3 rst = 1'b0;
        exp_q.delete();
        m_full = 1'b0;
        out_ready = 1'b1;
        abort = 1'b0;
        start = 1'b0;
        tick();
        return;
      end
      chk("busy", busy, (abort_j != 0) ? (j <= abort_j) : (j <= 241));
      chk("frame_done", frame_done, (abort_j == 0) && (j == 241));
      chk("flag_col_single", flag_col, 0);
      chk("err_overflow", err_overflow, m_ovf);
      r = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      out_ready = r;
      abort = (j == abort_j);
      start = (j == start_j);
      // Word k finishes on the edge ending cycle L+15+15k.
      if (j >= 15 && (j % 15) == 0 && j <= 240 && !(abort_j != 0 && j >= abort_j)) begin
        k = j / 15 - 1;
        if (!m_full || r) begin
          w.col  = 4'(NC - 1 - k);
          w.data = col_word[NC-1-k];
          exp_q.push_back(w);
          m_full = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end else if (r) begin
        m_full = 1'b0;
      end
    end
    abort = 1'b0;
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
    m_full = 1'b0;
    chk("drained_valid", out_valid, 0);
    chk("drained_queue", 32'(exp_q.size()), 0);
  endtask

  task automatic run_timeout();
    int seen_before;
    seen_before = flag_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 1; j <= 21; j++) begin
      chk("to_busy", busy, j <= 20);
      chk("to_err_timeout", err_timeout, j == 21);
      if (j < 21) tick();
    end
    chk("to_no_flag_col", 32'(flag_seen - seen_before), 0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    meas_done = 1'b0;
    out_ready = 1'b1;
    #12;
    chk_all_zero("reset");
    #5 rst = 1'b0;
    tick();

    run_frame(10, 0, 0, 0, 0, 1);   // nominal
    run_frame(10, 1, 0, 0, 0, 1);   // full backpressure
    run_timeout();
    run_frame(10, 0, 40, 0, 0, 1);  // abort at L+40
    run_frame(10, 0, 0, 0, 0, 1);   // recovery frame
    for (int i = 0; i < 3; i++)
      run_frame(int'($urandom_range(1, 19)), 2, 0, (i == 0) ? 50 : 0, 0, 0);
    run_frame(20, 2, 0, 0, 0, 0);   // meas_done on the timeout edge
    run_frame(10, 2, 0, 0, 100, 0); // reset mid-SHIFT
    run_frame(10, 0, 0, 0, 0, 1);

    chk("flag_col_count", 32'(flag_seen), 32'(flag_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
